// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access widths, FSM states
// and the store-side lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Unsigned widths exist only for loads; a request that is both read and write is rejected.
    function automatic logic is_illegal(input logic rd, input logic wr, input logic [2:0] f3);
        logic bad_f3;
        bad_f3 = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU));
        return bad_f3 | (wr & f3[2]) | (rd & wr);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) & lo[0]) | ((f3[1:0] == 2'b10) & (lo != 2'b00));
    endfunction

    function automatic logic [3:0] store_we(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane selection: picks the addressed byte/half from the read word and
// sign- or zero-extends it according to funct3.
import lsu_pkg::*;

module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory request per access,
// freezes the pipeline while waiting, and reports completion or fault.
//   state   | meaning
//   IDLE    | no access outstanding; accept/reject a new access
//   BUSY    | request on the bus, waiting for dm_ready or timeout
//   DONE    | one-cycle done (and optional fault) pulse
import lsu_pkg::*;

module mem_access_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        done,
    output logic        fault
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dm_req_q, dm_req_d;
    logic [3:0]        dm_we_q, dm_we_d;
    logic [31:0]       dm_addr_q, dm_addr_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              fault_q, fault_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_load_q, is_load_d;
    logic              access;
    logic              reject;
    logic [31:0]       align_data;

    lsu_load_align u_align (
        .rdata   (dm_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (align_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 4'h0;
            dm_addr_q  <= 32'h0;
            dm_wdata_q <= 32'h0;
            ld_data_q  <= 32'h0;
            fault_q    <= 1'b0;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            is_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            ld_data_q  <= ld_data_d;
            fault_q    <= fault_d;
            addr_lo_q  <= addr_lo_d;
            funct3_q   <= funct3_d;
            is_load_q  <= is_load_d;
        end
    end

    always_comb begin
        access     = mem_read | mem_write;
        reject     = is_illegal(mem_read, mem_write, funct3) | is_misaligned(funct3, alu_out[1:0]);
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        ld_data_d  = ld_data_q;
        fault_d    = 1'b0;
        addr_lo_d  = addr_lo_q;
        funct3_d   = funct3_q;
        is_load_d  = is_load_q;
        stall      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (reject) begin
                        fault_d   = 1'b1;
                        ld_data_d = 32'h0;
                        state_d   = ST_DONE;
                    end else begin
                        dm_req_d   = 1'b1;
                        dm_addr_d  = {alu_out[31:2], 2'b00};
                        dm_we_d    = mem_write ? store_we(funct3, alu_out[1:0]) : 4'h0;
                        dm_wdata_d = store_wdata(funct3, rs2_data);
                        addr_lo_d  = alu_out[1:0];
                        funct3_d   = funct3;
                        is_load_d  = mem_read;
                        cnt_d      = CNT_LOAD;
                        state_d    = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                // A completion on the final allowed cycle wins over the timeout.
                if (dm_ready) begin
                    dm_req_d = 1'b0;
                    cnt_d    = '0;
                    if (is_load_q) ld_data_d = align_data;
                    state_d  = ST_DONE;
                end else if (cnt_q == '0) begin
                    dm_req_d  = 1'b0;
                    fault_d   = 1'b1;
                    ld_data_d = 32'h0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign ld_data  = ld_data_q;
    assign done     = (state_q == ST_DONE);
    assign fault    = fault_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles in BUSY waiting for dm_ready before fault.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_out  input  32  byte address from the EX/MEM pipeline register.
REQ-005 rs2_data  input  32  store data from the EX/MEM pipeline register.
REQ-006 mem_read  input  1  load requested this stage.
REQ-007 mem_write  input  1  store requested this stage.
REQ-008 funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 dm_req  output  1  data-memory request, registered.
REQ-010 dm_we  output  4  byte write enables, all zero for loads.
REQ-011 dm_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-012 dm_wdata  output  32  lane-replicated store data.
REQ-013 dm_ready  input  1  memory completion; dm_rdata valid the same cycle.
REQ-014 dm_rdata  input  32  read word.
REQ-015 stall  output  1  freeze IF..MEM pipeline registers.
REQ-016 ld_data  output  32  aligned, extended load result, registered.
REQ-017 done  output  1  one-cycle pulse: access complete, ld_data/fault valid.
REQ-018 fault  output  1  one-cycle pulse with done: misaligned, illegal, or timeout.

Function
REQ-019 FSM states IDLE, BUSY, DONE; access = mem_read|mem_write.
REQ-020 IDLE, access, legal and aligned: latch dm_addr/dm_we/dm_wdata, dm_req<=1, ->BUSY.
REQ-021 IDLE, access illegal (funct3 011/110/111, store with funct3 1xx, or mem_read&mem_write) or misaligned (H/HU/SH with addr[0]=1; W with addr[1:0]!=0): no request, ->DONE with fault=1, ld_data<=0.
REQ-022 stall = (IDLE & access) | BUSY; stall=0 in DONE and in IDLE without access.
REQ-023 BUSY: dm_req, dm_addr, dm_we, dm_wdata held stable until dm_ready sampled high.
REQ-024 BUSY & dm_ready: dm_req<=0, ld_data<=extended dm_rdata (loads) or unchanged (stores), counter clear, ->DONE.
REQ-025 BUSY counter counts cycles; when count reaches TIMEOUT_CYC without dm_ready: dm_req<=0, fault pulse, ld_data<=0, ->DONE.
REQ-026 DONE: done=1 one cycle, inputs ignored, ->IDLE unconditionally.
REQ-027 dm_ready outside BUSY ignored.
REQ-028 Stores: SB dm_we=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH dm_we=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}; SW 4'b1111, wdata=rs2.
REQ-029 Loads: lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W passthrough.
REQ-030 Minimum latency: access at cycle 0, dm_req high cycle 1, dm_ready at cycle 1, done at cycle 2; stall high cycles 0-1.

Reset
REQ-031 rst asserted: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, ld_data=0, counter=0, done=0, fault=0 immediately.
REQ-032 Reset mid-BUSY abandons the access; no done pulse; stall follows inputs only after release.

Structure
REQ-033 Shared package lsu_pkg holds funct3 encodings and FSM state enum.
REQ-034 Sub-module lsu_load_align: combinational lane select and sign/zero extension.

Verification
REQ-035 LW addr 0x100, dm_ready after 3 cycles, rdata 0xDEADBEEF -> stall high 4 cycles, done with ld_data=0xDEADBEEF, fault=0.
REQ-036 LB addr 0x103, rdata 0x80FFFFFF -> ld_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202, rs2=0x1234ABCD -> dm_we=4'b1100, dm_wdata=0xABCDABCD, dm_addr=0x200.
REQ-038 LW addr 0x101 -> no dm_req, done+fault next cycle, ld_data=0.
REQ-039 LW, dm_ready never asserted, TIMEOUT_CYC=4 -> dm_req drops after 4 BUSY cycles, done+fault pulse.
REQ-040 rst asserted during BUSY -> dm_req=0 same cycle, state IDLE, no done pulse.
